sm_div_ctrl: RTL and testbench

//  Sequencing controller for signed-magnitude (SM) division by repeated subtraction.

---
 rtl/sm_div_pkg.sv | 20 ++
 rtl/sm_sub_step.sv | 14 +
 rtl/sm_div_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sm_div_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sm_div_pkg.sv
// rtl/sm_div_pkg.sv - shared types, widths and SM packing helper for the SM divider controller
package sm_div_pkg;

  localparam int W_MAG_DEF = 2;
  localparam int RES_W_DEF = 5;
  localparam int SIGN_BIT  = RES_W_DEF - 1;
  localparam int MAG_MSB   = RES_W_DEF - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A zero magnitude never carries a sign, so -0 cannot appear on the quotient.
  function automatic logic [SIGN_BIT:0] sm_pack(input logic sign, input logic [MAG_MSB:0] mag);
    sm_pack = {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/sm_sub_step.sv
// rtl/sm_sub_step.sv - combinational compare-and-subtract step of the repeated-subtraction divider
module sm_sub_step #(
  parameter int W = 2
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] den,
  output logic         ge,
  output logic [W-1:0] rem_next
);

  assign ge       = (rem >= den);
  assign rem_next = rem - den;

endmodule

// File: rtl/sm_div_ctrl.sv
// rtl/sm_div_ctrl.sv - iterative signed-magnitude quotient+remainder controller with valid/ready ports
// SM_DIV_BYPASS_EN: when defined, num mag < den mag skips the subtract loop and finishes from IDLE.
module sm_div_ctrl
  import sm_div_pkg::*;
#(
  parameter int W_MAG = W_MAG_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_MAG:0]   numerator,
  input  logic [W_MAG:0]   denominator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] quotient,
  output logic [RES_W-1:0] remainder,
  output logic             divbyzero,
  output logic             zero,
  output logic             busy
);

  localparam int PAD = RES_W - 1 - W_MAG;
  localparam logic [W_MAG-1:0] ITER_MAX = '1;

  state_e             state_q, state_d;
  logic [W_MAG-1:0]   rem_q, rem_d, q_q, q_d, den_q, den_d, iter_q, iter_d;
  logic               nsign_q, nsign_d, qsign_q, qsign_d;
  logic [RES_W-1:0]   quo_q, quo_d, remo_q, remo_d;
  logic               dbz_q, dbz_d, zero_q, zero_d, ov_q, ov_d;

  logic               ge;
  logic [W_MAG-1:0]   rem_next;
  logic [W_MAG-1:0]   num_mag, den_mag;
  logic [RES_W-2:0]   q_ext, rem_ext;

  assign num_mag = numerator[W_MAG-1:0];
  assign den_mag = denominator[W_MAG-1:0];
  assign q_ext   = {{PAD{1'b0}}, q_q};
  assign rem_ext = {{PAD{1'b0}}, rem_q};

`ifdef SM_DIV_BYPASS_EN
  logic [RES_W-2:0] num_ext;
  assign num_ext = {{PAD{1'b0}}, num_mag};
`endif

  sm_sub_step #(.W(W_MAG)) u_sub_step (
    .rem      (rem_q),
    .den      (den_q),
    .ge       (ge),
    .rem_next (rem_next)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    den_d   = den_q;
    iter_d  = iter_q;
    nsign_d = nsign_q;
    qsign_d = qsign_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = num_mag;
          q_d     = '0;
          iter_d  = '0;
          den_d   = den_mag;
          nsign_d = numerator[W_MAG];
          qsign_d = numerator[W_MAG] ^ denominator[W_MAG];
          if (den_mag == '0) begin
            state_d = DONE;
            quo_d   = '0;
            remo_d  = '0;
            zero_d  = 1'b0;
            dbz_d   = 1'b1;
          end
`ifdef SM_DIV_BYPASS_EN
          else if (num_mag < den_mag) begin
            state_d = DONE;
            quo_d   = '0;
            remo_d  = {numerator[W_MAG], num_ext};
            zero_d  = (num_mag == '0);
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        // The iteration bound only matters for illegal inputs; legal ones exit on ~ge first.
        if (ge && (iter_q != ITER_MAX)) begin
          rem_d  = rem_next;
          q_d    = q_q + 1'b1;
          iter_d = iter_q + 1'b1;
        end else begin
          state_d = DONE;
          quo_d   = sm_pack(qsign_q, q_ext);
          remo_d  = {nsign_q, rem_ext};
          zero_d  = (rem_q == '0);
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        // out_valid rises one edge after entering DONE, once results are settled.
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      den_q   <= '0;
      iter_q  <= '0;
      nsign_q <= 1'b0;
      qsign_q <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      den_q   <= den_d;
      iter_q  <= iter_d;
      nsign_q <= nsign_d;
      qsign_q <= qsign_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign divbyzero = dbz_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sm_div_ctrl.sv
// tb/tb_sm_div_ctrl.sv - directed scoreboard bench for sm_div_ctrl
module tb_sm_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] numerator = 3'b000;
  logic [2:0] denominator = 3'b000;
  logic       in_ready, out_valid, divbyzero, zero, busy;
  logic [4:0] quotient, remainder;

  always #5 clk = ~clk;

  sm_div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .numerator   (numerator),
    .denominator (denominator),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .divbyzero   (divbyzero),
    .zero        (zero),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0] quo;
    logic [4:0] rem;
    logic       dbz;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  function automatic exp_t model(input logic [2:0] n, input logic [2:0] d);
    exp_t       e;
    logic [1:0] nm, dm, qm, rm;
    nm = n[1:0];
    dm = d[1:0];
    if (dm == 2'd0) begin
      e.quo = 5'd0; e.rem = 5'd0; e.dbz = 1'b1; e.zero = 1'b0; e.lat = 1;
    end else begin
      qm    = nm / dm;
      rm    = nm % dm;
      e.quo = {(n[2] ^ d[2]) & (qm != 2'd0), 2'b00, qm};
      e.rem = {n[2], 2'b00, rm};
      e.dbz = 1'b0;
      e.zero = (rm == 2'd0);
      e.lat = int'(qm) + 2;
`ifdef SM_DIV_BYPASS_EN
      if (nm < dm) e.lat = 1;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [2:0] n, input logic [2:0] d, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid    = 1'b1;
    numerator   = n;
    denominator = d;
    sb.push_back(model(n, d));
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      if (lat == 0) begin
        chk("in_ready_busy", in_ready, 0);
        chk("busy_high", busy, 1);
      end
      @(posedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("quotient", quotient, e.quo);
    chk("remainder", remainder, e.rem);
    chk("divbyzero", divbyzero, e.dbz);
    chk("zero", zero, e.zero);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_quo", quotient, e.quo);
      chk("hold_rem", remainder, e.rem);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("retain_quo", quotient, e.quo);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    rst_n = 1'b1;

    run_op(3'b011, 3'b001, 0);
    run_op(3'b111, 3'b010, 0);
    run_op(3'b010, 3'b100, 0);
    run_op(3'b111, 3'b010, 5);
    run_op(3'b001, 3'b011, 0);
    run_op(3'b110, 3'b111, 0);
    run_op(3'b011, 3'b110, 0);

    @(negedge clk);
    in_valid    = 1'b1;
    numerator   = 3'b011;
    denominator = 3'b001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_quo", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_dbz", divbyzero, 0);
    chk("mid_rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_result_after_rst", seen, 0);
    chk("idle_after_rst", in_ready, 1);

    run_op(3'b011, 3'b001, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
